// File: rtl/microseq_control.sv
// Microcoded SAP control sequencer: fetch/execute driven by a writable microcode RAM,
// with halt/resume, single-step pause and a valid/ready program-load path.
module microseq_control #(
  parameter int                      OPCODE_W        = 4,
  parameter int                      CTRL_W          = 15,
  parameter int                      NUM_EXEC        = 3,
  parameter logic [OPCODE_W-1:0]     HLT_OPCODE      = 4'h0,
  parameter logic [CTRL_W-1:0]       IDLE_WORD       = 15'h0FE3,
  parameter logic [CTRL_W-1:0]       FETCH0_WORD     = 15'h27E3,
  parameter logic [CTRL_W-1:0]       FETCH1_WORD     = 15'h4FE3,
  parameter logic [CTRL_W-1:0]       FETCH2_WORD     = 15'h0D63,
  parameter logic [CTRL_W-1:0]       PROG_DATA_WORD  = 15'h0BE3,
  parameter logic [CTRL_W-1:0]       PROG_WRITE_WORD = 15'h0EE3,
  localparam int                     STEP_W          = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic                       programming,
  input  logic                       prog_valid,
  output logic                       prog_ready,
  output logic                       prog_done,
  input  logic                       step_mode,
  input  logic                       step,
  input  logic                       resume,
  input  logic                       uc_we,
  input  logic [OPCODE_W+STEP_W-1:0] uc_addr,
  input  logic [CTRL_W:0]            uc_wdata,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic                       halted,
  output logic                       instr_done
);

  localparam int unsigned UC_DEPTH = 2 ** (OPCODE_W + STEP_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_EXEC - 1);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_EX, S_HALT, S_PAUSE,
    S_PIDLE, S_PA, S_PI, S_PD, S_PW
  } state_t;

  state_t             state, state_next, boundary_next;
  logic [STEP_W-1:0]  step_cnt, step_cnt_next;
  logic [CTRL_W:0]    ucode [UC_DEPTH];
  logic [CTRL_W:0]    uc_word;

  assign uc_word = ucode[{opcode, step_cnt}];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_RST;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      step_cnt <= step_cnt_next;
    end
  end

  // Slots whose step field is beyond NUM_EXEC-1 are never executed, so writes there are dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < UC_DEPTH; i++) ucode[i] <= {1'b1, IDLE_WORD};
    end else if (uc_we && state != S_RST && uc_addr[STEP_W-1:0] <= LAST_STEP) begin
      ucode[uc_addr] <= uc_wdata;
    end
  end

  always_comb begin
    boundary_next = S_F0;
    if (programming)    boundary_next = S_PIDLE;
    else if (step_mode) boundary_next = S_PAUSE;
  end

  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    ctrl_out      = IDLE_WORD;
    halted        = 1'b0;
    prog_ready    = 1'b0;
    prog_done     = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_RST: begin
        step_cnt_next = '0;
        state_next    = programming ? S_PIDLE : S_F0;
      end
      S_F0: begin
        ctrl_out   = FETCH0_WORD;
        state_next = S_F1;
      end
      S_F1: begin
        ctrl_out   = FETCH1_WORD;
        state_next = S_F2;
      end
      S_F2: begin
        ctrl_out      = FETCH2_WORD;
        step_cnt_next = '0;
        state_next    = S_EX;
      end
      S_EX: begin
        if (step_cnt == '0 && opcode == HLT_OPCODE) begin
          step_cnt_next = '0;
          state_next    = S_HALT;
        end else begin
          ctrl_out = uc_word[CTRL_W-1:0];
          if (uc_word[CTRL_W] || step_cnt == LAST_STEP) begin
            instr_done    = 1'b1;
            step_cnt_next = '0;
            state_next    = boundary_next;
          end else begin
            step_cnt_next = step_cnt + 1'b1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (programming)  state_next = S_PIDLE;
        else if (resume)  state_next = S_F0;
      end
      S_PAUSE: begin
        if (programming)             state_next = S_PIDLE;
        else if (step || !step_mode) state_next = S_F0;
      end
      S_PIDLE: begin
        prog_ready = 1'b1;
        if (!programming)    state_next = S_F0;
        else if (prog_valid) state_next = S_PA;
      end
      S_PA: begin
        ctrl_out   = FETCH0_WORD;
        state_next = S_PI;
      end
      S_PI: begin
        ctrl_out   = FETCH1_WORD;
        state_next = S_PD;
      end
      S_PD: begin
        ctrl_out   = PROG_DATA_WORD;
        state_next = S_PW;
      end
      S_PW: begin
        ctrl_out   = PROG_WRITE_WORD;
        prog_done  = 1'b1;
        state_next = S_PIDLE;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_microseq_control.sv
// Bench for microseq_control: reset/fetch vector table, hand sequences for multi-cycle
// corners, then random stimulus against an instruction-level reference model.
module tb_microseq_control;
  localparam int OW = 4;
  localparam int CW = 15;
  localparam int NE = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          resetn, programming, prog_valid, prog_ready, prog_done;
  logic          step_mode, step, resume, uc_we, halted, instr_done;
  logic [OW-1:0] opcode;
  logic [OW+SW-1:0] uc_addr;
  logic [CW:0]   uc_wdata;
  logic [CW-1:0] ctrl_out;

  always #5 clk = ~clk;

  microseq_control #(.OPCODE_W(OW), .CTRL_W(CW), .NUM_EXEC(NE)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .programming(programming),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_done(prog_done),
    .step_mode(step_mode), .step(step), .resume(resume), .uc_we(uc_we),
    .uc_addr(uc_addr), .uc_wdata(uc_wdata), .ctrl_out(ctrl_out),
    .halted(halted), .instr_done(instr_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {halted, instr_done, prog_ready, prog_done};
  endfunction

  // Reference model: tracks which phase of machine activity we are in and how far along.
  typedef enum {M_RESET, M_FETCH, M_EXEC, M_HALT, M_PAUSE, M_LOAD} mode_t;
  mode_t       m_mode;
  int          m_pos;
  logic [CW-1:0] m_ctrl [16][NE];
  logic          m_end  [16][NE];

  task automatic m_boundary(input bit from_rst);
    m_pos = 0;
    if (programming)                 m_mode = M_LOAD;
    else if (!from_rst && step_mode) m_mode = M_PAUSE;
    else                             m_mode = M_FETCH;
  endtask

  task automatic model_edge();
    mode_t old_mode;
    int    ws;
    old_mode = m_mode;
    if (!resetn) begin
      m_mode = M_RESET;
      m_pos  = 0;
      for (int o = 0; o < 16; o++)
        for (int s = 0; s < NE; s++) begin
          m_ctrl[o][s] = 15'h0FE3;
          m_end[o][s]  = 1'b1;
        end
      return;
    end
    case (m_mode)
      M_RESET: m_boundary(1);
      M_FETCH: if (m_pos < 2) m_pos++; else begin m_mode = M_EXEC; m_pos = 0; end
      M_EXEC: begin
        if (m_pos == 0 && opcode == 4'h0) begin m_mode = M_HALT; m_pos = 0; end
        else if (m_end[opcode][m_pos] || m_pos == NE - 1) m_boundary(0);
        else m_pos++;
      end
      M_HALT: begin
        if (programming) begin m_mode = M_LOAD; m_pos = 0; end
        else if (resume) begin m_mode = M_FETCH; m_pos = 0; end
      end
      M_PAUSE: begin
        if (programming) begin m_mode = M_LOAD; m_pos = 0; end
        else if (step || !step_mode) begin m_mode = M_FETCH; m_pos = 0; end
      end
      M_LOAD: begin
        if (m_pos == 0) begin
          if (!programming) m_mode = M_FETCH;
          else if (prog_valid) m_pos = 1;
        end else if (m_pos == 4) m_pos = 0;
        else m_pos++;
      end
      default: ;
    endcase
    ws = int'(uc_addr[1:0]);
    if (uc_we && old_mode != M_RESET && ws < NE) begin
      m_ctrl[uc_addr[5:2]][ws] = uc_wdata[CW-1:0];
      m_end[uc_addr[5:2]][ws]  = uc_wdata[CW];
    end
  endtask

  function automatic void model_out(output logic [CW-1:0] c, output logic [3:0] f);
    c = 15'h0FE3;
    f = 4'b0000;
    case (m_mode)
      M_FETCH: c = (m_pos == 0) ? 15'h27E3 : (m_pos == 1) ? 15'h4FE3 : 15'h0D63;
      M_EXEC: if (!(m_pos == 0 && opcode == 4'h0)) begin
        c    = m_ctrl[opcode][m_pos];
        f[2] = m_end[opcode][m_pos] || m_pos == NE - 1;
      end
      M_HALT: f[3] = 1'b1;
      M_LOAD: case (m_pos)
        0: f[1] = 1'b1;
        1: c = 15'h27E3;
        2: c = 15'h4FE3;
        3: c = 15'h0BE3;
        default: begin c = 15'h0EE3; f[0] = 1'b1; end
      endcase
      default: ;
    endcase
  endfunction

  typedef struct packed {
    logic          rstn;
    logic          res;
    logic [OW-1:0] op;
    logic [CW-1:0] ctrl;
    logic [3:0]    fl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] ec;
    logic [3:0]    ef;
    int            ndone;

    resetn = 1'b0; programming = 1'b0; prog_valid = 1'b0; step_mode = 1'b0;
    step = 1'b0; resume = 1'b0; uc_we = 1'b0; uc_addr = '0; uc_wdata = '0; opcode = 4'h1;

    // {rstn, resume, opcode, ctrl_out, {halted, instr_done, prog_ready, prog_done}}
    tbl[0]  = '{1'b0, 1'b0, 4'h1, 15'h0FE3, 4'b0000};
    tbl[1]  = '{1'b1, 1'b0, 4'h1, 15'h27E3, 4'b0000};
    tbl[2]  = '{1'b1, 1'b0, 4'h1, 15'h4FE3, 4'b0000};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 15'h0D63, 4'b0000};
    tbl[4]  = '{1'b1, 1'b0, 4'h1, 15'h0FE3, 4'b0100};
    tbl[5]  = '{1'b1, 1'b0, 4'h1, 15'h27E3, 4'b0000};
    tbl[6]  = '{1'b1, 1'b0, 4'h1, 15'h4FE3, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 15'h0D63, 4'b0000};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 15'h0FE3, 4'b0000};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 15'h0FE3, 4'b1000};
    tbl[10] = '{1'b1, 1'b1, 4'h0, 15'h27E3, 4'b0000};
    tbl[11] = '{1'b1, 1'b1, 4'h0, 15'h4FE3, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      resetn = tbl[i].rstn; resume = tbl[i].res; opcode = tbl[i].op;
      tick();
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl_out), 32'(tbl[i].ctrl));
      chk($sformatf("vec%0d flags", i), 32'(flags()), 32'(tbl[i].fl));
    end
    resume = 1'b0;

    // Two-step instruction from microcode, and same-cycle write sees old data.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    uc_we = 1'b1; uc_addr = 6'h08; uc_wdata = {1'b0, 15'h1234}; tick();
    uc_addr = 6'h09; uc_wdata = {1'b1, 15'h2345}; tick();
    uc_we = 1'b0; opcode = 4'h2; tick();
    chk("mc x", 32'(ctrl_out), 32'h1234); chk("mc x flags", 32'(flags()), 32'h0);
    tick();
    chk("mc y", 32'(ctrl_out), 32'h2345); chk("mc y done", 32'(flags()), 32'h4);
    tick();
    chk("mc next f0", 32'(ctrl_out), 32'h27E3);
    tick(); tick(); tick();
    uc_we = 1'b1; uc_addr = 6'h08; uc_wdata = {1'b0, 15'h3456}; #1;
    chk("mc old read", 32'(ctrl_out), 32'h1234);
    tick(); uc_we = 1'b0;
    chk("mc y2", 32'(ctrl_out), 32'h2345);
    tick(); tick(); tick(); tick();
    chk("mc z", 32'(ctrl_out), 32'h3456);
    tick();
    chk("mc z then y", 32'(ctrl_out), 32'h2345);

    // Halt held for 10 cycles with step ignored, then resume+step together.
    resetn = 1'b0; tick(); resetn = 1'b1; opcode = 4'h0;
    tick(); tick(); tick(); tick();
    chk("halt ex", 32'(flags()), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step = k[0];
      tick();
      chk($sformatf("halt hold%0d", k), 32'({halted, ctrl_out}), 32'({1'b1, 15'h0FE3}));
    end
    resume = 1'b1; step = 1'b1; tick();
    chk("halt resume", 32'({halted, ctrl_out}), 32'({1'b0, 15'h27E3}));
    resume = 1'b0; step = 1'b0;

    // Single-step mode: pause after each instruction, one step = one instruction.
    resetn = 1'b0; tick(); resetn = 1'b1; step_mode = 1'b1; opcode = 4'h1;
    tick(); chk("ss f0 from rst", 32'(ctrl_out), 32'h27E3);
    tick(); tick(); tick(); chk("ss ex done", 32'(flags()), 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("ss pause%0d", k), 32'({flags(), ctrl_out}), 32'({4'h0, 15'h0FE3}));
    end
    step = 1'b1; tick(); step = 1'b0;
    chk("ss step f0", 32'(ctrl_out), 32'h27E3);
    tick(); chk("ss f1", 32'(ctrl_out), 32'h4FE3);
    tick(); chk("ss f2", 32'(ctrl_out), 32'h0D63);
    tick(); chk("ss ex2", 32'(flags()), 32'h4);
    tick(); chk("ss pause again", 32'({flags(), ctrl_out}), 32'({4'h0, 15'h0FE3}));
    tick(); chk("ss still paused", 32'(ctrl_out), 32'h0FE3);
    step_mode = 1'b0; tick(); chk("ss release", 32'(ctrl_out), 32'h27E3);

    // Programming requested mid-instruction, then three bytes loaded back to back.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    uc_we = 1'b1; uc_addr = 6'h0C; uc_wdata = {1'b0, 15'h1111}; tick();
    uc_addr = 6'h0D; uc_wdata = {1'b0, 15'h2222}; tick();
    uc_addr = 6'h0E; uc_wdata = {1'b0, 15'h3333}; opcode = 4'h3; tick();
    uc_we = 1'b0;
    chk("pg a", 32'(ctrl_out), 32'h1111);
    programming = 1'b1; tick();
    chk("pg b", 32'({flags(), ctrl_out}), 32'({4'h0, 15'h2222}));
    tick();
    chk("pg c", 32'({flags(), ctrl_out}), 32'({4'h4, 15'h3333}));
    tick();
    chk("pg idle", 32'(flags()), 32'h2);
    prog_valid = 1'b1; ndone = 0;
    for (int b = 0; b < 3; b++) begin
      tick(); chk($sformatf("pg%0d pa", b), 32'({flags(), ctrl_out}), 32'({4'h0, 15'h27E3}));
      tick(); chk($sformatf("pg%0d pi", b), 32'(ctrl_out), 32'h4FE3);
      tick(); chk($sformatf("pg%0d pd", b), 32'(ctrl_out), 32'h0BE3);
      tick(); chk($sformatf("pg%0d pw", b), 32'({flags(), ctrl_out}), 32'({4'h1, 15'h0EE3}));
      ndone += int'(prog_done);
      if (b == 2) prog_valid = 1'b0;
      tick(); chk($sformatf("pg%0d back", b), 32'({flags(), ctrl_out}), 32'({4'h2, 15'h0FE3}));
    end
    chk("pg done count", 32'(ndone), 32'd3);
    programming = 1'b0; tick();
    chk("pg exit", 32'(ctrl_out), 32'h27E3);

    // Reset during the data phase abandons the byte.
    resetn = 1'b0; tick(); resetn = 1'b1; programming = 1'b1; tick();
    chk("rpd idle", 32'(flags()), 32'h2);
    prog_valid = 1'b1; tick(); tick(); tick();
    chk("rpd pd", 32'(ctrl_out), 32'h0BE3);
    resetn = 1'b0; tick();
    chk("rpd rst", 32'({flags(), ctrl_out}), 32'({4'h0, 15'h0FE3}));
    resetn = 1'b1; programming = 1'b0; prog_valid = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ndone += int'(prog_done);
    end
    chk("rpd no done", 32'(ndone), 32'd0);

    // Random stimulus against the reference model.
    for (int i = 0; i < 2500; i++) begin
      resetn = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) programming = ~programming;
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
      step       = ($urandom_range(0, 7) == 0);
      resume     = ($urandom_range(0, 9) == 0);
      prog_valid = 1'($urandom_range(0, 1));
      uc_we      = ($urandom_range(0, 5) == 0);
      uc_addr    = 6'($urandom);
      uc_wdata   = 16'($urandom);
      opcode     = 4'($urandom);
      model_edge();
      tick();
      model_out(ec, ef);
      chk($sformatf("rnd%0d ctrl", i), 32'(ctrl_out), 32'(ec));
      chk($sformatf("rnd%0d flags", i), 32'(flags()), 32'(ef));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
